// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP, and the RESP cycle carries a one-cycle ack.
module mem_port_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_DATA-1:0] wdata0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 ack1,
    output logic [BITS_DATA-1:0] rdata,
    output logic [BITS_ADDR-1:0] MAR,
    output logic [BITS_DATA-1:0] MBR_W,
    output logic                 write,
    input  logic [BITS_DATA-1:0] MBR_R,
    output logic                 busy,
    output logic                 owner,
    output logic [1:0]           dbg_state
);

    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic          last_owner;
    logic          is_write;
    logic [CW-1:0] lat_cnt;
    logic          sel;

    // Handshake: a requester holds req/we/addr/wdata stable until its ack pulse
    // and drops req in the cycle after; a req still high back in IDLE is a new request.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) sel = ~last_owner;
        else if (req1)    sel = 1'b1;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            write      <= 1'b0;
            busy       <= 1'b0;
            MAR        <= '0;
            MBR_W      <= '0;
            rdata      <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            is_write   <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    if (req0 || req1) begin
                        MAR        <= sel ? addr1 : addr0;
                        MBR_W      <= sel ? wdata1 : wdata0;
                        write      <= sel ? we1 : we0;
                        is_write   <= sel ? we1 : we0;
                        owner      <= sel;
                        last_owner <= sel;
                        busy       <= 1'b1;
                        lat_cnt    <= CW'(MEM_LAT);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write strobe lasts only the first ACCESS cycle.
                    write <= 1'b0;
                    if (lat_cnt == CW'(1)) begin
                        if (!is_write) rdata <= MBR_R;
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
